keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans the 4×4 matrix keypad and delivers debounced key-press events to the game controller, which uses them as cursor and move input. It drives the keypad column lines, samples the row lines, and debounces the whole 16-key bitmap. For each new press it emits a single-cycle `key_valid` pulse with a 4-bit key code. It sits between the board keypad pins and `gomoku_main`, and replaces raw matrix handling inside the game logic.

## Interface
- `SCAN_DIV`, default 2500: `clk` cycles per column dwell (1 MHz clock gives 400 Hz column rate and 10 ms per frame); legal range ≥ 4.
- `DEBOUNCE_FRAMES`, default 2: number of additional identical frames required before a bitmap is committed; legal range ≥ 1.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `keyboard_row`, input, 4: row lines, active-low, externally pulled up, asynchronous to `clk`.
- `keyboard_col`, output, 4: column drive, one-hot active-low.
- `key_map`, output, 16: debounced pressed-key bitmap; bit index = col*4 + row.
- `key_code`, output, 4: code of the most recent press event.
- `key_valid`, output, 1: one-cycle pulse marking a new press.
- `key_held`, output, 1: `|key_map`.

## Operation
- **Synchronizer.** `keyboard_row` passes through a 2-flop synchronizer before use, giving `row_s`.
- **Column sequencing.**
  - Column index `col` runs 0, 1, 2, 3, 0, … and advances when the dwell counter reaches `SCAN_DIV-1`.
  - `keyboard_col` = ~(1 << `col`), registered.
- **Sampling.**
  - In the last dwell cycle of column c, `raw[c*4 +: 4]` ← ~`row_s`.
  - Sampling at the end of the dwell allows settling and synchronizer delay.
- **Frame end.**
  - When column 3 is sampled, the FSM enters COMMIT for one cycle. Column 0 is already being driven during that cycle.
- **FSM states.** SCAN (dwell counting and sampling) and COMMIT (one cycle). SCAN→COMMIT at column 3 sample; COMMIT→SCAN unconditionally.
- **Debounce, evaluated in COMMIT.**
  - If `raw != prev_raw`: `stable_cnt` ← 0.
  - Else if `stable_cnt < DEBOUNCE_FRAMES`: `stable_cnt` ← `stable_cnt+1`.
  - When `stable_cnt` transitions to `DEBOUNCE_FRAMES`: `key_map` ← `raw`.
  - `prev_raw` ← `raw`.
  - `stable_cnt` saturates at `DEBOUNCE_FRAMES`; its width is clog2(`DEBOUNCE_FRAMES`+1).
- **Press event.**
  - On a commit, `new` = `raw` & ~`key_map`_old.
  - If `new` ≠ 0: `key_code` ← index of the lowest set bit of `new`, and `key_valid` pulses.
  - Any other new bits in the same commit are absorbed into `key_map` without an event.
  - Releases update `key_map` only. They never pulse `key_valid`.
- **Held keys.** A key held continuously produces exactly one event; there is no auto-repeat.

## Timing
- **Reset values.**
  - Outputs: `keyboard_col` = 4'b1110, `key_map` = 0, `key_code` = 0, `key_valid` = 0, `key_held` = 0.
  - Internal: `col` = 0, dwell counter = 0, `raw` = 0, `prev_raw` = 0, `stable_cnt` = 0, FSM in SCAN.
- **Frame length.** 4·`SCAN_DIV` cycles.
- **Commit latency.**
  - `key_map`, `key_code` and `key_valid` all change in the cycle after COMMIT, together.
  - `key_held` follows `key_map` combinationally from the register.
- **Press latency.** A key held from the start of frame k commits at the end of frame k+`DEBOUNCE_FRAMES`. If the press starts mid-frame, the first frame it fully covers is frame k.
- **Bounce.** Any bounce that changes `raw` between frames restarts the count. A press shorter than `DEBOUNCE_FRAMES`+1 frames produces no event.
- **Reset mid-scan.** Asynchronous reset returns all state to the reset values immediately. No event may be emitted during the first `DEBOUNCE_FRAMES`+1 frames after reset.
- **Ghosting.** With three or more keys pressed, matrix ghosting may set extra `raw` bits. These are reported as seen; no ghost suppression.

## Structure
- **Shared package.** The shared `gomoku_defs` package/include holds `KB_ROWS`=4, `KB_COLS`=4, `KEY_CODE_W`=4 and the named key-code constants used by `gomoku_main`: up, down, left, right, place.
- **Sub-module.** One sub-module, `sync_2ff`, a 4-bit two-flop synchronizer with async active-low reset to 1 (rows idle high).

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_FRAMES`=2, giving a 16-cycle frame.
- **Reset and idle.** Hold reset, release, rows all 1 for 10 frames → `keyboard_col` cycles 1110, 1101, 1011, 0111 every 4 cycles; `key_valid` never asserts; `key_map` = 0.
- **Single press.** Key (col 2, row 1) pressed continuously → exactly one `key_valid` pulse with `key_code`=9, one cycle after the third stable COMMIT; `key_map` = 16'h0200; `key_held`=1.
- **Bounce.** Toggle key 5 every frame for 6 frames, then hold → no event during toggling; one event with code 5, 3 frames after the hold begins.
- **Simultaneous presses.** Keys 3 and 12 pressed in the same frame → one event, code 3; `key_map` = 16'h1008.
- **Release then press.** Release all, wait for commit, then press key 0 → `key_map` returns to 0 with no pulse; then one pulse with code 0.
- **Reset mid-debounce.** Assert `rst_n` low for 1 cycle during the 2nd stable frame of a press → all outputs at reset values; the event occurs only after 3 full stable frames post-reset.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: matrix geometry, key-code width, the key codes
// the game controller interprets as cursor/move input, the scan FSM states
// and a helper that picks the lowest pressed key out of a bitmap.
package keypad_scanner_pkg;

  localparam int KB_ROWS    = 4;
  localparam int KB_COLS    = 4;
  localparam int KEY_CODE_W = 4;
  localparam int KEY_MAP_W  = KB_ROWS * KB_COLS;

  // Key codes are col*4 + row; these are the ones gomoku_main acts on.
  localparam logic [KEY_CODE_W-1:0] KEY_UP    = 4'd1;
  localparam logic [KEY_CODE_W-1:0] KEY_LEFT  = 4'd4;
  localparam logic [KEY_CODE_W-1:0] KEY_PLACE = 4'd5;
  localparam logic [KEY_CODE_W-1:0] KEY_RIGHT = 4'd6;
  localparam logic [KEY_CODE_W-1:0] KEY_DOWN  = 4'd9;

  typedef enum logic [0:0] {
    ST_SCAN   = 1'b0,
    ST_COMMIT = 1'b1
  } scan_state_e;

  // Index of the lowest set bit; zero when no bit is set.
  function automatic logic [KEY_CODE_W-1:0] lowest_key(input logic [KEY_MAP_W-1:0] bits);
    logic [KEY_CODE_W-1:0] idx;
    idx = {KEY_CODE_W{1'b0}};
    for (int i = KEY_MAP_W - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx = KEY_CODE_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event bus from the keypad scanner to the game controller.
interface keypad_scanner_if;
  import keypad_scanner_pkg::*;

  logic [KEY_MAP_W-1:0]  key_map;
  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  key_held;

  modport master (
    output key_map,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    input key_map,
    input key_code,
    input key_valid,
    input key_held
  );

endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for the keypad row lines. Resets to all ones so the
// rows read as idle (pulled up, nothing pressed) straight out of reset.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{1'b1}};
      sync_r <= {WIDTH{1'b1}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns, samples the rows at the end
// of each column dwell, debounces the full 16-key bitmap across frames and
// emits one key_valid pulse per new press with the lowest new key's code.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV        = 2500,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KB_ROWS-1:0] keyboard_row,
  output logic [KB_COLS-1:0] keyboard_col,
  keypad_scanner_if.master   key_if
);

  localparam int DW_W  = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int COL_W = $clog2(KB_COLS);

  localparam logic [DW_W-1:0]    DWELL_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ARM    = CNT_W'(DEBOUNCE_FRAMES - 1);
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(KB_COLS - 1);
  localparam logic [KB_COLS-1:0] COL_ONE    = KB_COLS'(1);

  // Synchronized rows, active-low like the pins.
  logic [KB_ROWS-1:0]    row_s;

  // Column sequencing.
  logic [DW_W-1:0]       dwell_r;
  logic [COL_W-1:0]      col_r;
  logic [COL_W-1:0]      col_next_s;
  logic [KB_COLS-1:0]    keyboard_col_r;
  logic                  dwell_end_s;
  logic                  frame_end_s;

  // Frame capture and debounce.
  logic [KEY_MAP_W-1:0]  raw_r;
  logic [KEY_MAP_W-1:0]  raw_next_s;
  logic [KEY_MAP_W-1:0]  prev_raw_r;
  logic [CNT_W-1:0]      stable_cnt_r;
  logic                  raw_same_s;
  logic                  settle_s;
  logic [KEY_MAP_W-1:0]  new_keys_s;

  // Scan FSM.
  scan_state_e           state_r;
  scan_state_e           state_next_s;
  logic                  commit_s;

  // Registered event outputs.
  logic [KEY_MAP_W-1:0]  key_map_r;
  logic [KEY_CODE_W-1:0] key_code_r;
  logic                  key_valid_r;

  sync_2ff #(
    .WIDTH(KB_ROWS)
  ) u_row_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (keyboard_row),
    .q    (row_s)
  );

  assign dwell_end_s = (dwell_r == DWELL_LAST);
  assign frame_end_s = dwell_end_s && (col_r == COL_LAST);

  // Column index for the next cycle; wraps 3 -> 0.
  always_comb begin
    col_next_s = col_r;
    if (dwell_end_s) begin
      if (col_r == COL_LAST) begin
        col_next_s = {COL_W{1'b0}};
      end else begin
        col_next_s = col_r + COL_W'(1);
      end
    end else begin
      col_next_s = col_r;
    end
  end

  // Dwell counter, column index and registered one-hot-low column drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_r        <= {DW_W{1'b0}};
      col_r          <= {COL_W{1'b0}};
      keyboard_col_r <= ~COL_ONE;
    end else begin
      if (dwell_end_s) begin
        dwell_r <= {DW_W{1'b0}};
      end else begin
        dwell_r <= dwell_r + DW_W'(1);
      end
      col_r          <= col_next_s;
      keyboard_col_r <= ~(COL_ONE << col_next_s);
    end
  end

  // Capture the active column's rows into the raw bitmap on the last dwell
  // cycle, once the column drive and synchronizer have settled.
  always_comb begin
    raw_next_s = raw_r;
    for (int c = 0; c < KB_COLS; c++) begin
      if (dwell_end_s && (col_r == COL_W'(c))) begin
        raw_next_s[c*KB_ROWS +: KB_ROWS] = ~row_s;
      end else begin
        raw_next_s[c*KB_ROWS +: KB_ROWS] = raw_r[c*KB_ROWS +: KB_ROWS];
      end
    end
  end

  // Raw bitmap register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_r <= {KEY_MAP_W{1'b0}};
    end else begin
      raw_r <= raw_next_s;
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_SCAN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Scan FSM next state: one COMMIT cycle after the column-3 sample, while
  // column 0 of the next frame is already being driven.
  always_comb begin
    state_next_s = state_r;
    commit_s     = 1'b0;
    case (state_r)
      ST_SCAN: begin
        if (frame_end_s) begin
          state_next_s = ST_COMMIT;
        end else begin
          state_next_s = ST_SCAN;
        end
      end
      ST_COMMIT: begin
        state_next_s = ST_SCAN;
        commit_s     = 1'b1;
      end
      default: begin
        state_next_s = ST_SCAN;
      end
    endcase
  end

  assign raw_same_s = (raw_r == prev_raw_r);
  // The bitmap is accepted on the commit where the stable count reaches its
  // target; a saturated count never re-commits the same bitmap.
  assign settle_s   = commit_s && raw_same_s && (stable_cnt_r == CNT_ARM);
  assign new_keys_s = raw_r & ~key_map_r;

  // Frame-to-frame stability tracking, updated once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_raw_r   <= {KEY_MAP_W{1'b0}};
      stable_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (commit_s) begin
        prev_raw_r <= raw_r;
        if (!raw_same_s) begin
          stable_cnt_r <= {CNT_W{1'b0}};
        end else if (stable_cnt_r < CNT_MAX) begin
          stable_cnt_r <= stable_cnt_r + CNT_W'(1);
        end else begin
          stable_cnt_r <= stable_cnt_r;
        end
      end else begin
        prev_raw_r   <= prev_raw_r;
        stable_cnt_r <= stable_cnt_r;
      end
    end
  end

  // Debounced key map and press event; releases only update the map.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_map_r   <= {KEY_MAP_W{1'b0}};
      key_code_r  <= {KEY_CODE_W{1'b0}};
      key_valid_r <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      if (settle_s) begin
        key_map_r <= raw_r;
        if (|new_keys_s) begin
          key_code_r  <= lowest_key(new_keys_s);
          key_valid_r <= 1'b1;
        end else begin
          key_code_r <= key_code_r;
        end
      end else begin
        key_map_r  <= key_map_r;
        key_code_r <= key_code_r;
      end
    end
  end

  assign keyboard_col     = keyboard_col_r;
  assign key_if.key_map   = key_map_r;
  assign key_if.key_code  = key_code_r;
  assign key_if.key_valid = key_valid_r;
  assign key_if.key_held  = |key_map_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 16-cycle frame (SCAN_DIV=4,
// DEBOUNCE_FRAMES=2). A behavioural matrix drives the rows from a bitmap of
// pressed keys; a table of press phases is applied frame-aligned, followed by
// a hand-written reset-during-debounce sequence.
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_FRAMES = 2;
  localparam int FRAME           = 4 * SCAN_DIV;
  // Pulse visible at the negedge after posedge 3*FRAME+1 counted from the
  // phase start: three stable commits, then one register cycle.
  localparam int EVT_AT          = (DEBOUNCE_FRAMES + 1) * FRAME + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  keyboard_row;
  logic [3:0]  keyboard_col;
  logic [15:0] pressed = 16'h0000;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .keyboard_row(keyboard_row),
    .keyboard_col(keyboard_col),
    .key_if      (kif)
  );

  always #5 clk = ~clk;

  // Matrix model: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    keyboard_row = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!keyboard_col[c] && pressed[c*4 + r]) keyboard_row[r] = 1'b0;
      end
    end
  end

  int checks = 0;
  int fails  = 0;
  int t      = 0;
  int pulses = 0;
  int pulse_t = 0;
  logic [3:0] pulse_code = 4'h0;

  typedef struct {
    logic [15:0] press;
    int          frames;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic [15:0] exp_map;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // One clock: sample at the negedge, then step 1 time unit so stimulus
  // changes land clear of the sampling point.
  task automatic tick();
    logic [3:0] exp_col;
    logic [3:0] one;
    @(negedge clk);
    if (rst_n) begin
      t++;
      one = 4'b0001;
      exp_col = ~(one << ((t / SCAN_DIV) % 4));
      check("col_drive", {28'h0, keyboard_col}, {28'h0, exp_col});
      check("key_held", {31'h0, kif.key_held}, {31'h0, |kif.key_map});
      if (kif.key_valid) begin
        pulses++;
        pulse_t = t;
        pulse_code = kif.key_code;
      end
    end
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_col"},   {28'h0, keyboard_col}, 32'h0000000e);
    check({tag, "_map"},   {16'h0, kif.key_map},  32'h00000000);
    check({tag, "_code"},  {28'h0, kif.key_code}, 32'h00000000);
    check({tag, "_valid"}, {31'h0, kif.key_valid}, 32'h00000000);
    check({tag, "_held"},  {31'h0, kif.key_held}, 32'h00000000);
  endtask

  initial begin
    int t0;
    int p0;

    // Idle, single press, held (no repeat), release.
    vecs[0]  = '{16'h0000, 10, 0, 4'h0, 16'h0000};
    vecs[1]  = '{16'h0200,  4, 1, 4'h9, 16'h0200};
    vecs[2]  = '{16'h0200,  4, 0, 4'h0, 16'h0200};
    vecs[3]  = '{16'h0000,  4, 0, 4'h0, 16'h0000};
    // Key 5 bouncing every frame, then held.
    vecs[4]  = '{16'h0020,  1, 0, 4'h0, 16'h0000};
    vecs[5]  = '{16'h0000,  1, 0, 4'h0, 16'h0000};
    vecs[6]  = '{16'h0020,  1, 0, 4'h0, 16'h0000};
    vecs[7]  = '{16'h0000,  1, 0, 4'h0, 16'h0000};
    vecs[8]  = '{16'h0020,  1, 0, 4'h0, 16'h0000};
    vecs[9]  = '{16'h0000,  1, 0, 4'h0, 16'h0000};
    vecs[10] = '{16'h0020,  4, 1, 4'h5, 16'h0020};
    // Keys 3 and 12 together: lowest reported, both mapped.
    vecs[11] = '{16'h1008,  4, 1, 4'h3, 16'h1008};
    // Release all, then key 0.
    vecs[12] = '{16'h0000,  4, 0, 4'h0, 16'h0000};
    vecs[13] = '{16'h0001,  4, 1, 4'h0, 16'h0001};
    // Add key 15 while key 0 held, then release key 0 only.
    vecs[14] = '{16'h8001,  4, 1, 4'hf, 16'h8001};
    vecs[15] = '{16'h8000,  4, 0, 4'h0, 16'h8000};

    // Reset held for a few cycles.
    pressed = 16'h0000;
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    t = 0;

    for (int i = 0; i < NV; i++) begin
      pressed = vecs[i].press;
      t0 = t;
      p0 = pulses;
      repeat (vecs[i].frames * FRAME) tick();
      check($sformatf("v%0d_pulses", i), pulses - p0, vecs[i].exp_pulses);
      if (vecs[i].exp_pulses > 0) begin
        check($sformatf("v%0d_code", i), {28'h0, pulse_code}, {28'h0, vecs[i].exp_code});
        check($sformatf("v%0d_when", i), pulse_t - t0, EVT_AT);
      end
      check($sformatf("v%0d_map", i), {16'h0, kif.key_map}, {16'h0, vecs[i].exp_map});
      check($sformatf("v%0d_held", i), {31'h0, kif.key_held}, {31'h0, |vecs[i].exp_map});
    end

    // Reset in the middle of the second stable frame of a press of key 9,
    // while key 15 is still in the map and key_code holds 15.
    pressed = 16'h0200;
    repeat (FRAME + FRAME / 2) tick();
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    tick();
    rst_n = 1'b1;
    t = 0;
    p0 = pulses;
    repeat (EVT_AT - 1) tick();
    check("midrst_no_early", pulses - p0, 0);
    repeat (4 * FRAME - (EVT_AT - 1)) tick();
    check("midrst_pulses", pulses - p0, 1);
    check("midrst_code", {28'h0, pulse_code}, 32'h00000009);
    check("midrst_when", pulse_t, EVT_AT);
    check("midrst_map", {16'h0, kif.key_map}, 32'h00000200);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
